vliw_packet_loader: RTL and testbench
=====================================

Name: vliw_packet_loader

Overview:
- Writer side of the VLIW instruction memory. Accepts a stream of 32-bit slot instructions over a valid/ready handshake.
- Packs every 10 slots into one 320-bit issue packet and writes it into instruction memory at consecutive addresses.
- Loads the program that the fetch stage later reads with inst[pc]. Runs before the processor is released and sits between the testbench/host program source and instruction memory.

Parameters:
- INST_MEM_SIZE, 1024, instruction memory depth in packets.
- SLOTS, 10, slots per packet. Fixed at 10 in this revision.
- ADDR_W, 10, instruction memory address width; must satisfy 2^ADDR_W >= INST_MEM_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a load at base_addr.
- base_addr  in  ADDR_W  first packet address, sampled on start.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  loader can accept in_word.
- in_word  in  32  slot instruction; slot order 0..9 (ADD0, ADD1, MUL, FADD0, FADD1, FMUL, LOGIC, LDR, STR, MOV).
- in_last  in  1  marks the final word of the program; qualified by in_valid.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  packet address for the write.
- wr_data  out  320  packet; slot 0 in [319:288], slot 9 in [31:0].
- busy  out  1  high in COLLECT and WRITE.
- done  out  1  load complete; held until the next start or rst.
- pkt_count  out  ADDR_W+1  packets written since start.
- overflow  out  1  sticky; address wrapped past INST_MEM_SIZE-1.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state goes to IDLE.
  - in_ready, wr_en, busy, done and overflow are 0.
  - wr_addr, wr_data, pkt_count, slot index and slot buffer are 0.
  - rst has priority over every other input, including mid-packet. A partially collected packet is discarded and nothing is written.
- States:
  - IDLE:
    - in_ready=0.
    - start → COLLECT; wr_addr<=base_addr, pkt_count<=0, overflow<=0, done<=0, slot index<=0, buffer<=0.
  - COLLECT:
    - in_ready=1.
    - Handshake: a word is accepted when in_valid && in_ready at posedge. The accepted word goes into buffer slot [idx], and idx increments.
    - If the accepted word is slot 9, or in_last=1 → WRITE. Unfilled slots stay 0, which is a NOP: opcode 0 targeting r0, and r0 is forced to zero.
    - in_valid=0 holds state; no timeout.
  - WRITE (exactly one cycle):
    - in_ready=0, wr_en=1, wr_data=buffer, wr_addr=current address.
    - On exit: pkt_count+=1, buffer<=0, idx<=0.
    - Address advance: wr_addr<=(wr_addr==INST_MEM_SIZE-1) ? 0 : wr_addr+1. A wrap sets overflow (sticky) and the load continues.
    - If the packet was closed by in_last → DONE; otherwise → COLLECT.
  - DONE:
    - done=1, in_ready=0.
    - start → COLLECT with the same initialisation as IDLE; done falls on the cycle after start is sampled.
- Start handling: start is ignored in COLLECT and WRITE.
- Timing:
  - Latency: 1 cycle from acceptance of the closing word to wr_en=1.
  - Throughput: 10 words per 11 cycles.
- Boundary cases:
  - in_last on slot 9 produces one full packet and no extra empty packet.
  - in_last on slot 0 produces one packet with slots 1..9 zero.
  - Starting at base_addr=INST_MEM_SIZE-1 with 2 packets writes addresses 1023 then 0, and overflow=1.
- wr_data and wr_addr are registered and are don't-care when wr_en=0. They hold their last value.

Optional Feature:
- Macro: PKT_SLOT_CHECK_EN.
- When defined, the loader checks memory-slot opcodes (in_word[31:27]) on acceptance:
  - slot 7 must be 5'b00000 or 5'b10010.
  - slot 8 must be 5'b00000 or 5'b10011.
  - slot 9 must be 5'b00000 or 5'b10100.
- On a violation:
  - the word is replaced by 32'h0 in the buffer.
  - new output slot_err (1 bit, sticky) is set.
  - slot_err clears on start or rst.
- When undefined, there is no check, no slot_err port, and words are stored unmodified.

Test Plan:
- rst, then start with base_addr=0, 20 words 32'h0000_0001..32'h0000_0014, in_last on word 20 → wr_en at addr 0 and 1; addr 1 slot 0 = 32'h0000_000B, slot 9 = 32'h0000_0014; pkt_count=2; done=1.
- start base_addr=5, 3 words with in_last on the 3rd → one write at addr 5, wr_data[319:224] = the 3 words, wr_data[223:0]=0.
- start base_addr=1023, 11 words, last on word 11 → writes at 1023 then 0; overflow=1; second packet has only slot 0 nonzero.
- in_valid toggled 1/0 every cycle during a 10-word packet → no word lost or duplicated; wr_en exactly once; in_ready=0 during the WRITE cycle.
- rst asserted after 4 accepted words → no wr_en; all outputs 0 next cycle; a new start loads cleanly from base_addr.
- With PKT_SLOT_CHECK_EN, slot 8 word 32'h9000_0000 (opcode 10010) → slot 8 written as 0, slot_err=1.

Source files
------------

// File: rtl/vliw_packet_loader.sv
// Packs a stream of 32-bit slot instructions into SLOTS-wide issue packets and
// writes them to instruction memory. Optional opcode check via PKT_SLOT_CHECK_EN.
module vliw_packet_loader #(
  parameter int INST_MEM_SIZE = 1024,
  parameter int SLOTS         = 10,
  parameter int ADDR_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_word,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [32*SLOTS-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       pkt_count,
  output logic                  overflow
`ifdef PKT_SLOT_CHECK_EN
  ,
  output logic                  slot_err
`endif
);

  localparam int IDX_W = $clog2(SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t                  state;
  logic [SLOTS-1:0][31:0]  buffer;
  logic [SLOTS-1:0][31:0]  buf_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    last_q;
  logic                    accept;
  logic                    closing;
  logic                    slot_bad;
  logic [31:0]             word_eff;

  assign accept  = (state == S_COLLECT) && in_valid && in_ready;
  assign closing = accept && ((idx == IDX_W'(SLOTS-1)) || in_last);

  // Memory slots (LDR/STR/MOV) only accept NOP or their own opcode.
  always_comb begin
    slot_bad = 1'b0;
`ifdef PKT_SLOT_CHECK_EN
    if (idx == IDX_W'(7)) slot_bad = (in_word[31:27] != 5'b00000) && (in_word[31:27] != 5'b10010);
    if (idx == IDX_W'(8)) slot_bad = (in_word[31:27] != 5'b00000) && (in_word[31:27] != 5'b10011);
    if (idx == IDX_W'(9)) slot_bad = (in_word[31:27] != 5'b00000) && (in_word[31:27] != 5'b10100);
`endif
    word_eff = slot_bad ? 32'h0 : in_word;
  end

  // Slot 0 lives in the most significant word of the packet.
  always_comb begin
    buf_nxt = buffer;
    for (int s = 0; s < SLOTS; s++)
      if (idx == IDX_W'(s)) buf_nxt[SLOTS-1-s] = word_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pkt_count <= '0;
      idx       <= '0;
      buffer    <= '0;
      last_q    <= 1'b0;
`ifdef PKT_SLOT_CHECK_EN
      slot_err  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_COLLECT;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            wr_addr   <= base_addr;
            pkt_count <= '0;
            overflow  <= 1'b0;
            idx       <= '0;
            buffer    <= '0;
`ifdef PKT_SLOT_CHECK_EN
            slot_err  <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (accept) begin
`ifdef PKT_SLOT_CHECK_EN
            if (slot_bad) slot_err <= 1'b1;
`endif
            if (closing) begin
              state    <= S_WRITE;
              in_ready <= 1'b0;
              wr_en    <= 1'b1;
              wr_data  <= buf_nxt;
              last_q   <= in_last;
            end else begin
              buffer <= buf_nxt;
              idx    <= idx + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          pkt_count <= pkt_count + (ADDR_W+1)'(1);
          buffer    <= '0;
          idx       <= '0;
          if (wr_addr == ADDR_W'(INST_MEM_SIZE-1)) begin
            wr_addr  <= '0;
            overflow <= 1'b1;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
          if (last_q) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_COLLECT;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_packet_loader.sv
// Directed bench for vliw_packet_loader: a packet-level model predicts every
// memory write; a negedge monitor compares each wr_en cycle against it.
module tb_vliw_packet_loader;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_ready, in_last, wr_en, busy, done, overflow;
  logic [9:0]   base_addr, wr_addr;
  logic [31:0]  in_word;
  logic [319:0] wr_data;
  logic [10:0]  pkt_count;
`ifdef PKT_SLOT_CHECK_EN
  logic         slot_err;
`endif

  vliw_packet_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .pkt_count(pkt_count), .overflow(overflow)
`ifdef PKT_SLOT_CHECK_EN
    , .slot_err(slot_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] a; logic [319:0] d; } wr_t;

  int           total = 0;
  int           bad   = 0;
  wr_t          exp_q[$];
  logic [9:0]   act_addr[$];
  logic [319:0] act_data[$];
  wr_t          mon_e;

  task automatic chk(string nm, logic [319:0] act, logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Model: word i lands in packet i/10, slot i%10; packets go to consecutive
  // addresses modulo the memory depth; unfilled slots are zero.
  function automatic void plan(input logic [9:0] base, input logic [31:0] w[$],
                               output int npk, output logic ovf);
    wr_t e;
    npk = (w.size() + 9) / 10;
    for (int p = 0; p < npk; p++) begin
      e.a = 10'((int'(base) + p) % 1024);
      e.d = '0;
      for (int s = 0; s < 10; s++) begin
        logic [31:0] v;
        if (p*10 + s >= w.size()) continue;
        v = w[p*10 + s];
`ifdef PKT_SLOT_CHECK_EN
        if (s == 7 && v[31:27] != 5'd0 && v[31:27] != 5'b10010) v = 0;
        if (s == 8 && v[31:27] != 5'd0 && v[31:27] != 5'b10011) v = 0;
        if (s == 9 && v[31:27] != 5'd0 && v[31:27] != 5'b10100) v = 0;
`endif
        e.d[319-32*s -: 32] = v;
      end
      exp_q.push_back(e);
    end
    ovf = (int'(base) + npk >= 1024);
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      act_addr.push_back(wr_addr);
      act_data.push_back(wr_data);
      chk("ready_in_write", in_ready, 0);
      chk("busy_in_write", busy, 1);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write act_addr=%0d exp=none", wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e.a);
        chk("wr_data", wr_data, mon_e.d);
      end
    end
  end

  task automatic do_start(input logic [9:0] b);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_word = w; in_last = l;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("handshake_timeout", acc, 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 100);
    chk({nm, "_done"}, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input string nm, input logic [9:0] base,
                          input logic [31:0] w[$], input bit toggle);
    int   npk;
    logic ovf;
    act_addr.delete(); act_data.delete();
    plan(base, w, npk, ovf);
    do_start(base);
    chk({nm, "_done_fall"}, done, 0);
    chk({nm, "_ready"}, in_ready, 1);
    foreach (w[i]) begin
      send(w[i], i == w.size() - 1);
      if (toggle && i != w.size() - 1) begin @(posedge clk); #1; end
    end
    wait_done(nm);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_pkt_count"}, pkt_count, npk);
    chk({nm, "_overflow"}, overflow, ovf);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ready_idle"}, in_ready, 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, in_ready, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ovf"}, overflow, 0);
    chk({nm, "_addr"}, wr_addr, 0);
    chk({nm, "_data"}, wr_data, 0);
    chk({nm, "_cnt"}, pkt_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [95:0] three;
    rst = 1'b1; start = 0; base_addr = 0; in_valid = 0; in_word = 0; in_last = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;

    // Two full packets from address 0.
    w.delete();
    for (int i = 1; i <= 20; i++) w.push_back(32'(i));
    run_load("t1", 10'd0, w, 0);
    chk("t1_nwr", act_addr.size(), 2);
    chk("t1_addr0", act_addr[0], 0);
    chk("t1_addr1", act_addr[1], 1);
    chk("t1_slot0", act_data[1][319:288], 32'h0000_000B);
    chk("t1_slot9", act_data[1][31:0], 32'h0000_0014);
    chk("t1_cnt_lit", pkt_count, 2);

    // Short packet closed by in_last on slot 2.
    w = '{32'hA1, 32'hB2, 32'hC3};
    run_load("t2", 10'd5, w, 0);
    three = {32'hA1, 32'hB2, 32'hC3};
    chk("t2_addr", act_addr[0], 5);
    chk("t2_hi", act_data[0][319:224], three);
    chk("t2_lo", act_data[0][223:0], 0);

    // Wrap from the top of memory, second packet holds only slot 0.
    w.delete();
    for (int i = 1; i <= 11; i++) w.push_back(32'h100 + 32'(i));
    run_load("t3", 10'd1023, w, 0);
    chk("t3_addr0", act_addr[0], 1023);
    chk("t3_addr1", act_addr[1], 0);
    chk("t3_ovf_lit", overflow, 1);
    chk("t3_p1_slot0", act_data[1][319:288], 32'h10B);
    chk("t3_p1_rest", act_data[1][287:0], 0);

    // Gapped in_valid, in_last on slot 9: exactly one packet.
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(32'hDEAD_0000 + 32'(i));
    run_load("t4", 10'd100, w, 1);
    chk("t4_nwr", act_addr.size(), 1);
    chk("t4_slot3", act_data[0][223:192], 32'hDEAD_0003);

    // Reset mid-packet discards the partial packet.
    act_addr.delete();
    do_start(10'd200);
    for (int i = 0; i < 4; i++) send(32'h55 + 32'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("t5");
    repeat (3) @(posedge clk);
    #1;
    chk("t5_nwr", act_addr.size(), 0);

    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    run_load("t6", 10'd7, w, 0);
    chk("t6_addr", act_addr[0], 7);
    chk("t6_slot4", act_data[0][191:160], 32'h55);

`ifdef PKT_SLOT_CHECK_EN
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(i == 8 ? 32'h9000_0000 : 32'(i + 1));
    run_load("t7", 10'd50, w, 0);
    chk("t7_slot8", act_data[0][63:32], 0);
    chk("t7_slot_err", slot_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
